// File: rtl/nat_seq_gen.sv
// Arithmetic-sequence operand source for the summation pipeline.
// Streams first_val, first_val+step, ... over valid/ready and pulses done when the run ends.
module nat_seq_gen #(
  parameter int N_MAX = 512,
  parameter int DW    = 10,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] first_val,
  input  logic [CW-1:0] count,
  input  logic [3:0]    step,
  output logic [DW-1:0] op_data,
  output logic          op_valid,
  input  logic          op_ready,
  output logic          op_last,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [3:0]    step_q, step_d;

  logic [CW-1:0] clamped;
  logic [DW:0]   sum;

  assign clamped = (count > CW'(N_MAX)) ? CW'(N_MAX) : count;
  // The extra top bit of sum is the carry that flags a wrapped operand.
  assign sum     = {1'b0, data_q} + {{(DW - 3){1'b0}}, step_q};

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          step_d = step;
          rem_d  = clamped;
          ovf_d  = 1'b0;
          if (clamped == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            data_d  = first_val;
            valid_d = 1'b1;
            last_d  = (clamped == CW'(1));
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (valid_q && op_ready) begin
          if (last_q) begin
            state_d = DONE;
            data_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            rem_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            data_d = sum[DW-1:0];
            rem_d  = rem_q - CW'(1);
            last_d = (rem_q == CW'(2));
            if (sum[DW]) ovf_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
    end
  end

  assign op_data  = data_q;
  assign op_valid = valid_q;
  assign op_last  = last_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_nat_seq_gen.sv
// Directed bench for nat_seq_gen: streaming, stalls, clamp, wrap, zero count and mid-run reset.
module tb_nat_seq_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] first_val;
  logic [9:0] count;
  logic [3:0] step;
  logic [9:0] op_data;
  logic       op_valid;
  logic       op_ready;
  logic       op_last;
  logic       busy;
  logic       done;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  int acc      = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  nat_seq_gen dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .first_val(first_val),
    .count    (count),
    .step     (step),
    .op_data  (op_data),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_last  (op_last),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [9:0] fv, input logic [9:0] cnt, input logic [3:0] stp);
    first_val = fv;
    count     = cnt;
    step      = stp;
    start     = 1'b1;
    tick;
    start     = 1'b0;
  endtask

  // Runs from the first post-start sample until the beat after the last transfer,
  // checking every beat against a locally computed sequence.
  task automatic collect(input int n, input logic [9:0] fv, input logic [3:0] stp,
                         input logic [5:0] pat, input int pulse_at, output int cycles);
    logic [9:0]  exp_d;
    logic [10:0] nxt;
    logic [9:0]  held_d;
    logic        held_l;
    logic        ovf_exp;
    logic        stalled;
    int          idx;
    int          c;
    exp_d   = fv;
    ovf_exp = 1'b0;
    stalled = 1'b0;
    held_d  = '0;
    held_l  = 1'b0;
    idx     = 0;
    c       = 0;
    acc     = 0;
    check("busy_at_start", {31'd0, busy}, 1);
    while (idx < n && c < 4000) begin
      op_ready = pat[c % 6];
      start    = (c == pulse_at);
      if (stalled) begin
        check("stall_data", {22'd0, op_data}, {22'd0, held_d});
        check("stall_last", {31'd0, op_last}, {31'd0, held_l});
      end
      check("valid", {31'd0, op_valid}, 1);
      check("overflow", {31'd0, overflow}, {31'd0, ovf_exp});
      if (op_ready) begin
        check("data", {22'd0, op_data}, {22'd0, exp_d});
        check("last", {31'd0, op_last}, {31'd0, (idx == n - 1)});
        acc += int'(op_data);
        nxt = {1'b0, exp_d} + {7'd0, stp};
        if (idx != n - 1 && nxt[10]) ovf_exp = 1'b1;
        exp_d   = nxt[9:0];
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held_d  = op_data;
        held_l  = op_last;
      end
      tick;
      c++;
    end
    start    = 1'b0;
    op_ready = 1'b1;
    check("beats", idx, n);
    check("done_pulse", {31'd0, done}, 1);
    check("busy_end", {31'd0, busy}, 0);
    check("valid_end", {31'd0, op_valid}, 0);
    cycles = c;
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    op_ready  = 1'b0;
    first_val = '0;
    count     = '0;
    step      = '0;
    tick;
    tick;
    check("rst_data", {22'd0, op_data}, 0);
    check("rst_valid", {31'd0, op_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    reset = 1'b1;
    tick;

    // Full 1..512 run with a free-flowing consumer.
    do_start(10'd1, 10'd512, 4'd1);
    collect(512, 10'd1, 4'd1, 6'b111111, -1, cyc);
    check("cycles_512", cyc, 512);
    check("sum_512", acc, 131328);
    tick;
    check("idle_done", {31'd0, done}, 0);

    // Same run with ready pattern 1,0,0,1,0,1.
    do_start(10'd1, 10'd512, 4'd1);
    collect(512, 10'd1, 4'd1, 6'b101001, -1, cyc);
    check("sum_stall", acc, 131328);
    tick;

    // Zero-length run, then a short run.
    do_start(10'd5, 10'd0, 4'd1);
    check("zero_done", {31'd0, done}, 1);
    check("zero_valid", {31'd0, op_valid}, 0);
    check("zero_busy", {31'd0, busy}, 0);
    tick;
    check("zero_idle_done", {31'd0, done}, 0);
    check("zero_idle_valid", {31'd0, op_valid}, 0);
    do_start(10'd5, 10'd3, 4'd1);
    collect(3, 10'd5, 4'd1, 6'b111111, -1, cyc);
    tick;

    // Wrap past 1023 sets sticky overflow; next start clears it.
    do_start(10'd1020, 10'd6, 4'd1);
    collect(6, 10'd1020, 4'd1, 6'b111111, -1, cyc);
    check("ovf_sticky", {31'd0, overflow}, 1);
    tick;
    check("ovf_idle", {31'd0, overflow}, 1);
    do_start(10'd3, 10'd2, 4'd1);
    collect(2, 10'd3, 4'd1, 6'b111111, -1, cyc);
    check("ovf_cleared", {31'd0, overflow}, 0);
    tick;

    // Reset while stalled after 10 accepted beats.
    do_start(10'd100, 10'd20, 4'd2);
    op_ready = 1'b1;
    repeat (10) tick;
    op_ready = 1'b0;
    tick;
    check("pre_rst_data", {22'd0, op_data}, 120);
    check("pre_rst_valid", {31'd0, op_valid}, 1);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    check("mid_rst_data", {22'd0, op_data}, 0);
    check("mid_rst_valid", {31'd0, op_valid}, 0);
    check("mid_rst_last", {31'd0, op_last}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_done", {31'd0, done}, 0);
    check("mid_rst_ovf", {31'd0, overflow}, 0);
    do_start(10'd50, 10'd4, 4'd3);
    collect(4, 10'd50, 4'd3, 6'b111111, -1, cyc);
    tick;

    // Count 700 clamps to 512; a start pulsed mid-run is ignored.
    do_start(10'd0, 10'd700, 4'd2);
    collect(512, 10'd0, 4'd2, 6'b111111, 5, cyc);
    check("clamp_cycles", cyc, 512);
    tick;
    check("clamp_idle_valid", {31'd0, op_valid}, 0);
    check("clamp_idle_busy", {31'd0, busy}, 0);

    // Step 0 gives a constant stream.
    do_start(10'd7, 10'd5, 4'd0);
    collect(5, 10'd7, 4'd0, 6'b111111, -1, cyc);
    check("step0_sum", acc, 35);
    check("step0_ovf", {31'd0, overflow}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
